// File: rtl/xor_vga_ctrl_pkg.sv
// Shared definitions for the xor_vga control sequencer: mode encodings,
// configuration reset defaults, sequencer state encodings and small helpers.
package xor_vga_ctrl_pkg;

    // Pattern mode encodings understood by the xor_vga core
    localparam logic [1:0] MODE_PLAIN_XOR    = 2'd0;
    localparam logic [1:0] MODE_AND          = 2'd1;
    localparam logic [1:0] MODE_XOR_VSCROLL  = 2'd2;
    localparam logic [1:0] MODE_AND_VSCROLL  = 2'd3;

    // Reset defaults for the user-editable configuration
    localparam logic [1:0] MODE_RST    = MODE_PLAIN_XOR;
    localparam logic [2:0] SPEED_RST   = 3'd1;
    localparam logic [2:0] PALETTE_RST = 3'd0;

    // Commit sequencer state encodings
    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_PENDING = 2'd1;
    localparam logic [1:0] ST_COMMIT  = 2'd2;

    // One complete configuration word as seen by the pattern core
    typedef struct packed {
        logic [1:0] mode;
        logic [2:0] speed;
        logic [2:0] palette;
    } cfg_t;

    localparam cfg_t CFG_RST = '{mode: MODE_RST, speed: SPEED_RST, palette: PALETTE_RST};

    // Speed advances by one and wraps from the configured maximum back to frozen
    function automatic logic [2:0] speed_inc(input logic [2:0] speed, input logic [2:0] max_speed);
        logic [2:0] nxt;
        if (speed >= max_speed) begin
            nxt = 3'd0;
        end else begin
            nxt = speed + 3'd1;
        end
        return nxt;
    endfunction

    // Modes with bit 1 set also scroll vertically
    function automatic logic mode_has_vscroll(input logic [1:0] mode);
        return mode[1];
    endfunction

endpackage

// File: rtl/xor_vga_ctrl_button_debounce.sv
// Raw push-button conditioning: 2-FF synchroniser, stability counter and
// rising-edge detector. The accepted level only moves once the synchronised
// input has disagreed with it for DEBOUNCE_CYCLES consecutive samples.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 315000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta_r;
    logic             sync_r;
    logic [CNT_W-1:0] cnt_r;
    logic             level_r;
    logic             press_r;
    logic             differ_s;
    logic             settle_s;

    // Detect a disagreement and the sample on which it has lasted long enough
    always_comb begin
        differ_s = sync_r ^ level_r;
        settle_s = differ_s & (cnt_r == CNT_LAST);
    end

    // Two-stage synchroniser for the asynchronous button
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta_r <= 1'b0;
            sync_r      <= 1'b0;
        end else begin
            sync_meta_r <= btn;
            sync_r      <= sync_meta_r;
        end
    end

    // Count consecutive samples that disagree with the accepted level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= CNT_ZERO;
        end else if (!differ_s || settle_s) begin
            cnt_r <= CNT_ZERO;
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    // Accept the new level and flag a 0->1 transition as a one-cycle press
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_r <= 1'b0;
            press_r <= 1'b0;
        end else if (settle_s) begin
            level_r <= sync_r;
            press_r <= sync_r;
        end else begin
            level_r <= level_r;
            press_r <= 1'b0;
        end
    end

    assign level = level_r;
    assign press = press_r;

endmodule

// File: rtl/xor_vga_ctrl.sv
// Control sequencer for the xor_vga pattern core. Button presses edit a
// shadow configuration; the edit reaches the active outputs only after a
// frame_start, so the picture never changes mid-frame. Scroll offsets
// advance once per frame using the speed active before any commit.
module xor_vga_ctrl
    import xor_vga_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 315000,
    parameter int MAX_SPEED       = 7,
    parameter int SCROLL_W        = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                but1,
    input  logic                but2,
    input  logic                but3,
    input  logic                frame_start,
    output logic [1:0]          mode,
    output logic [2:0]          speed,
    output logic [2:0]          palette,
    output logic [SCROLL_W-1:0] scroll_x,
    output logic [SCROLL_W-1:0] scroll_y,
    output logic                cfg_update
);

    localparam logic [2:0]          MAX_SPEED_L = 3'(MAX_SPEED);
    localparam logic [SCROLL_W-1:0] SCROLL_RST  = {SCROLL_W{1'b0}};

    logic [2:0]          level_s;
    logic [2:0]          press_s;
    logic                any_press_s;
    cfg_t                shadow_r;
    cfg_t                shadow_next_s;
    cfg_t                active_r;
    logic [1:0]          state_r;
    logic [1:0]          state_next_s;
    logic                cfg_update_r;
    logic [SCROLL_W-1:0] scroll_x_r;
    logic [SCROLL_W-1:0] scroll_y_r;
    logic [SCROLL_W-1:0] scroll_step_s;

    // Button conditioning: index 0 = mode, 1 = speed, 2 = palette
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_mode (
        .clk   (clk),
        .reset (reset),
        .btn   (but1),
        .level (level_s[0]),
        .press (press_s[0])
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_speed (
        .clk   (clk),
        .reset (reset),
        .btn   (but2),
        .level (level_s[1]),
        .press (press_s[1])
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_palette (
        .clk   (clk),
        .reset (reset),
        .btn   (but3),
        .level (level_s[2]),
        .press (press_s[2])
    );

    // Next shadow configuration from this cycle's press pulses
    always_comb begin
        shadow_next_s = shadow_r;
        any_press_s   = |press_s;
        if (press_s[2] && level_s[0]) begin
            // palette press while the mode button is held restores defaults
            shadow_next_s = CFG_RST;
        end else begin
            if (press_s[0]) begin
                shadow_next_s.mode = shadow_r.mode + 2'd1;
            end else begin
                shadow_next_s.mode = shadow_r.mode;
            end
            if (press_s[1]) begin
                shadow_next_s.speed = speed_inc(shadow_r.speed, MAX_SPEED_L);
            end else begin
                shadow_next_s.speed = shadow_r.speed;
            end
            if (press_s[2]) begin
                shadow_next_s.palette = shadow_r.palette + 3'd1;
            end else begin
                shadow_next_s.palette = shadow_r.palette;
            end
        end
    end

    // Commit sequencer: a press in RUN always waits for a later frame_start
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (any_press_s) begin
                    state_next_s = ST_PENDING;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_PENDING: begin
                if (frame_start) begin
                    state_next_s = ST_COMMIT;
                end else begin
                    state_next_s = ST_PENDING;
                end
            end
            ST_COMMIT: begin
                if (any_press_s) begin
                    state_next_s = ST_PENDING;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            default: begin
                state_next_s = ST_RUN;
            end
        endcase
    end

    // Per-frame scroll increment derived from the currently active speed
    always_comb begin
        scroll_step_s = SCROLL_W'(active_r.speed);
    end

    // Shadow configuration and sequencer state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_r <= CFG_RST;
            state_r  <= ST_RUN;
        end else begin
            shadow_r <= shadow_next_s;
            state_r  <= state_next_s;
        end
    end

    // Active configuration: loaded from the shadow value held at the start of COMMIT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_r     <= CFG_RST;
            cfg_update_r <= 1'b0;
        end else if (state_r == ST_COMMIT) begin
            active_r     <= shadow_r;
            cfg_update_r <= 1'b1;
        end else begin
            active_r     <= active_r;
            cfg_update_r <= 1'b0;
        end
    end

    // Scroll accumulators advance once per frame, wrapping naturally at 2^SCROLL_W
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scroll_x_r <= SCROLL_RST;
            scroll_y_r <= SCROLL_RST;
        end else if (frame_start) begin
            scroll_x_r <= scroll_x_r + scroll_step_s;
            if (mode_has_vscroll(active_r.mode)) begin
                scroll_y_r <= scroll_y_r + scroll_step_s;
            end else begin
                scroll_y_r <= scroll_y_r;
            end
        end else begin
            scroll_x_r <= scroll_x_r;
            scroll_y_r <= scroll_y_r;
        end
    end

    assign mode       = active_r.mode;
    assign speed      = active_r.speed;
    assign palette    = active_r.palette;
    assign scroll_x   = scroll_x_r;
    assign scroll_y   = scroll_y_r;
    assign cfg_update = cfg_update_r;

endmodule
